// File: rtl/snitch_icache_pkg.sv
// Shared icache types: L0/L1 performance-event bundles and counter index mapping.
package snitch_icache_pkg;

   localparam int unsigned L0_EVENT_COUNT = 5;
   localparam int unsigned L1_EVENT_COUNT = 4;

   // Declared MSB-first so l0_miss lands on bit 0.
   typedef struct packed {
      logic l0_stall;
      logic l0_double_hit;
      logic l0_prefetch;
      logic l0_hit;
      logic l0_miss;
   } icache_l0_events_t;

   typedef struct packed {
      logic l1_handler_stall;
      logic l1_stall;
      logic l1_hit;
      logic l1_miss;
   } icache_l1_events_t;

   // L1 events use port == NR_FETCH_PORTS, i.e. they follow the last L0 block.
   function automatic int unsigned perf_ctr_idx(input int unsigned port, input int unsigned evt);
      return port * L0_EVENT_COUNT + evt;
   endfunction

endpackage

// File: rtl/snitch_icache_perf_ctr_if.sv
// Single-cycle request/response read port of the icache performance counter bank.
interface snitch_icache_perf_ctr_if #(
   parameter int unsigned AW        = 4,
   parameter int unsigned CNT_WIDTH = 32
);
   logic                 rd_req_i;
   logic [AW-1:0]        rd_addr_i;
   logic                 rd_valid_o;
   logic [CNT_WIDTH-1:0] rd_data_o;
   logic                 rd_ovf_o;
   logic                 rd_err_o;

   modport master (
      output rd_req_i, rd_addr_i,
      input  rd_valid_o, rd_data_o, rd_ovf_o, rd_err_o
   );

   modport slave (
      input  rd_req_i, rd_addr_i,
      output rd_valid_o, rd_data_o, rd_ovf_o, rd_err_o
   );
endinterface

// File: rtl/snitch_icache_perf_cnt.sv
// One performance counter: +1 per inc, saturating or wrapping, with a sticky overflow flag.
module snitch_icache_perf_cnt #(
   parameter int unsigned CNT_WIDTH = 32,
   parameter bit          SATURATE  = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 inc_i,
   input  logic                 clear_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 ovf_o
);

   logic at_max;
   assign at_max = &cnt_o;

   // Clear outranks an increment in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cnt_o <= '0;
         ovf_o <= 1'b0;
      end else if (inc_i) begin
         if (at_max) begin
            ovf_o <= 1'b1;
            cnt_o <= SATURATE ? cnt_o : '0;
         end else begin
            cnt_o <= cnt_o + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/snitch_icache_perf_ctr.sv
// Per-port icache performance-event counter bank with shadow snapshot, clear and a registered read port.
module snitch_icache_perf_ctr
   import snitch_icache_pkg::*;
#(
   parameter int unsigned NR_FETCH_PORTS = 1,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter bit          SATURATE       = 1'b1,
   parameter bit          SNAPSHOT       = 1'b1
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    enable_i,
   input  logic                                    clear_i,
   input  logic                                    snapshot_i,
   input  icache_l0_events_t [NR_FETCH_PORTS-1:0]  l0_events_i,
   input  icache_l1_events_t                       l1_events_i,
   snitch_icache_perf_ctr_if.slave                 rd
);

   localparam int unsigned NUM_CNT  = NR_FETCH_PORTS * L0_EVENT_COUNT + L1_EVENT_COUNT;
   localparam int unsigned AW       = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
   localparam int unsigned NUM_SLOT = 2 ** AW;

   if (CNT_WIDTH < 2 || NR_FETCH_PORTS < 1) begin : g_bad_param
      $error("snitch_icache_perf_ctr: CNT_WIDTH must be >= 2 and NR_FETCH_PORTS >= 1");
   end
   if ($bits(icache_l0_events_t) != L0_EVENT_COUNT ||
       $bits(icache_l1_events_t) != L1_EVENT_COUNT) begin : g_bad_event_width
      $error("snitch_icache_perf_ctr: event struct widths disagree with L0/L1_EVENT_COUNT");
   end

   logic [NUM_CNT-1:0] ev_d;
   logic [NUM_CNT-1:0] ev_q;

   // Flatten the event bundles into counter order.
   for (genvar p = 0; p < NR_FETCH_PORTS; p++) begin : g_l0_port
      for (genvar b = 0; b < L0_EVENT_COUNT; b++) begin : g_l0_bit
         assign ev_d[perf_ctr_idx(p, b)] = l0_events_i[p][b];
      end
   end
   for (genvar b = 0; b < L1_EVENT_COUNT; b++) begin : g_l1_bit
      assign ev_d[perf_ctr_idx(NR_FETCH_PORTS, b)] = l1_events_i[b];
   end

   // Events sampled during clear are dropped along with the ones already registered.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i || !enable_i) begin
         ev_q <= '0;
      end else begin
         ev_q <= ev_d;
      end
   end

   logic [CNT_WIDTH-1:0] live_cnt [NUM_CNT];
   logic [NUM_CNT-1:0]   live_ovf;

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      snitch_icache_perf_cnt #(
         .CNT_WIDTH (CNT_WIDTH),
         .SATURATE  (SATURATE)
      ) u_cnt (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .inc_i   (ev_q[i]),
         .clear_i (clear_i),
         .cnt_o   (live_cnt[i]),
         .ovf_o   (live_ovf[i])
      );
   end

   logic [CNT_WIDTH-1:0] bank_cnt [NUM_CNT];
   logic [NUM_CNT-1:0]   bank_ovf;

   if (SNAPSHOT) begin : g_shadow
      logic [CNT_WIDTH-1:0] shadow_cnt [NUM_CNT];
      logic [NUM_CNT-1:0]   shadow_ovf;

      // Captures pre-edge live values, so a coincident clear is not seen.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
               shadow_cnt[i] <= '0;
            end
            shadow_ovf <= '0;
         end else if (snapshot_i) begin
            shadow_cnt <= live_cnt;
            shadow_ovf <= live_ovf;
         end
      end

      assign bank_cnt = shadow_cnt;
      assign bank_ovf = shadow_ovf;
   end else begin : g_live
      logic unused_snapshot;
      assign unused_snapshot = snapshot_i;
      assign bank_cnt        = live_cnt;
      assign bank_ovf        = live_ovf;
   end

   // Pad the bank to a power of two so every address decodes; the padding reports an error.
   logic [CNT_WIDTH-1:0] slot_cnt [NUM_SLOT];
   logic [NUM_SLOT-1:0]  slot_ovf;
   logic [NUM_SLOT-1:0]  slot_err;

   for (genvar i = 0; i < NUM_SLOT; i++) begin : g_slot
      if (i < NUM_CNT) begin : g_used
         assign slot_cnt[i] = bank_cnt[i];
         assign slot_ovf[i] = bank_ovf[i];
         assign slot_err[i] = 1'b0;
      end else begin : g_pad
         assign slot_cnt[i] = '0;
         assign slot_ovf[i] = 1'b0;
         assign slot_err[i] = 1'b1;
      end
   end

   logic                 rd_valid_q;
   logic [CNT_WIDTH-1:0] rd_data_q;
   logic                 rd_ovf_q;
   logic                 rd_err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_ovf_q   <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd.rd_req_i;
         if (rd.rd_req_i) begin
            rd_data_q <= slot_cnt[rd.rd_addr_i];
            rd_ovf_q  <= slot_ovf[rd.rd_addr_i];
            rd_err_q  <= slot_err[rd.rd_addr_i];
         end
      end
   end

   assign rd.rd_valid_o = rd_valid_q;
   assign rd.rd_data_o  = rd_data_q;
   assign rd.rd_ovf_o   = rd_ovf_q;
   assign rd.rd_err_o   = rd_err_q;

endmodule

// File: tb/tb_snitch_icache_perf_ctr.sv
// Scoreboard bench: a saturating and a wrapping bank (2 ports, 4-bit counters) driven in lockstep.
module tb_snitch_icache_perf_ctr;
   import snitch_icache_pkg::*;

   localparam int unsigned NR  = 2;
   localparam int unsigned W   = 4;
   localparam int unsigned NUM = 14;
   localparam int unsigned AW  = 4;

   typedef struct packed {
      logic [W-1:0] data;
      logic         ovf;
      logic         err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b1;
   logic clear = 1'b0;
   logic snapshot = 1'b0;
   logic rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [NUM-1:0] ev_flat = '0;

   icache_l0_events_t [NR-1:0] l0_ev;
   icache_l1_events_t          l1_ev;
   assign l0_ev = ev_flat[9:0];
   assign l1_ev = ev_flat[13:10];

   exp_t q_s[$];
   exp_t q_w[$];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   snitch_icache_perf_ctr_if #(.AW(AW), .CNT_WIDTH(W)) rd_s ();
   snitch_icache_perf_ctr_if #(.AW(AW), .CNT_WIDTH(W)) rd_w ();
   assign rd_s.rd_req_i  = rd_req;
   assign rd_s.rd_addr_i = rd_addr;
   assign rd_w.rd_req_i  = rd_req;
   assign rd_w.rd_addr_i = rd_addr;

   snitch_icache_perf_ctr #(.NR_FETCH_PORTS(NR), .CNT_WIDTH(W), .SATURATE(1'b1), .SNAPSHOT(1'b1)) u_sat (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear), .snapshot_i(snapshot),
      .l0_events_i(l0_ev), .l1_events_i(l1_ev), .rd(rd_s)
   );

   snitch_icache_perf_ctr #(.NR_FETCH_PORTS(NR), .CNT_WIDTH(W), .SATURATE(1'b0), .SNAPSHOT(1'b1)) u_wrap (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear), .snapshot_i(snapshot),
      .l0_events_i(l0_ev), .l1_events_i(l1_ev), .rd(rd_w)
   );

   function automatic exp_t mk(input int d, input bit o, input bit e);
      exp_t r;
      r.data = W'(d);
      r.ovf  = o;
      r.err  = e;
      return r;
   endfunction

   function automatic logic [6:0] got_s();
      return {rd_s.rd_valid_o, rd_s.rd_data_o, rd_s.rd_ovf_o, rd_s.rd_err_o};
   endfunction

   function automatic logic [6:0] got_w();
      return {rd_w.rd_valid_o, rd_w.rd_data_o, rd_w.rd_ovf_o, rd_w.rd_err_o};
   endfunction

   task automatic issue(input int addr, input exp_t es, input exp_t ew);
      rd_req  = 1'b1;
      rd_addr = AW'(addr);
      q_s.push_back(es);
      q_w.push_back(ew);
   endtask

   task automatic pulses(input logic [NUM-1:0] mask, input int n, input bit spaced);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ev_flat = mask;
         if (spaced) begin
            @(negedge clk);
            ev_flat = '0;
         end
      end
      @(negedge clk);
      ev_flat = '0;
   endtask

   task automatic snap();
      repeat (2) @(negedge clk);
      snapshot = 1'b1;
      @(negedge clk);
      snapshot = 1'b0;
   endtask

   task automatic clr();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      exp_t es, ew;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (rd_s.rd_valid_o !== 1'b0 || rd_w.rd_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid: sat=%b wrap=%b want 0", rd_s.rd_valid_o, rd_w.rd_valid_o);
      end
      for (int i = 0; i <= int'(NUM); i++) begin
         @(negedge clk);
         if (i > 0) begin
            vectors++;
            es = q_s.pop_front();
            ew = q_w.pop_front();
            if (got_s() !== {1'b1, es} || got_w() !== {1'b1, ew}) begin
               miscompares++;
               $display("FAIL reset_rd idx %0d: sat %h want %h, wrap %h want %h", i - 1, got_s(), {1'b1, es}, got_w(), {1'b1, ew});
            end
         end
         if (i < int'(NUM)) issue(i, mk(0, 0, 0), mk(0, 0, 0));
         else rd_req = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if (rd_s.rd_valid_o !== 1'b0 || rd_w.rd_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL valid_drop: sat=%b wrap=%b want 0", rd_s.rd_valid_o, rd_w.rd_valid_o);
      end
   endtask

   task automatic test_count();
      exp_t es, ew;
      int d;
      clr();
      pulses((NUM'(1) << 6) | (NUM'(1) << 10), 3, 1'b1);
      pulses(NUM'(1) << 6, 4, 1'b1);
      snap();
      for (int i = 0; i <= int'(NUM); i++) begin
         @(negedge clk);
         if (i > 0) begin
            vectors++;
            es = q_s.pop_front();
            ew = q_w.pop_front();
            if (got_s() !== {1'b1, es} || got_w() !== {1'b1, ew}) begin
               miscompares++;
               $display("FAIL count_rd idx %0d: sat %h want %h, wrap %h want %h", i - 1, got_s(), {1'b1, es}, got_w(), {1'b1, ew});
            end
         end
         if (i < int'(NUM)) begin
            d = (i == 6) ? 7 : (i == 10) ? 3 : 0;
            issue(i, mk(d, 0, 0), mk(d, 0, 0));
         end else begin
            rd_req = 1'b0;
         end
      end
   endtask

   task automatic test_overflow();
      exp_t es, ew;
      int   n_p[3];
      exp_t xs[3];
      exp_t xw[3];
      n_p = '{15, 1, 4};
      xs  = '{mk(15, 0, 0), mk(15, 1, 0), mk(15, 1, 0)};
      xw  = '{mk(15, 0, 0), mk(0, 1, 0), mk(4, 1, 0)};
      clr();
      for (int s = 0; s < 3; s++) begin
         pulses(NUM'(1), n_p[s], 1'b0);
         snap();
         @(negedge clk);
         issue(0, xs[s], xw[s]);
         @(negedge clk);
         rd_req = 1'b0;
         vectors++;
         es = q_s.pop_front();
         ew = q_w.pop_front();
         if (got_s() !== {1'b1, es} || got_w() !== {1'b1, ew}) begin
            miscompares++;
            $display("FAIL overflow stage %0d: sat %h want %h, wrap %h want %h", s, got_s(), {1'b1, es}, got_w(), {1'b1, ew});
         end
      end
   endtask

   task automatic test_clear_snapshot();
      exp_t es, ew;
      int   d[3];
      d = '{5, 0, 0};
      clr();
      pulses(NUM'(1) << 2, 5, 1'b1);
      for (int s = 0; s < 3; s++) begin
         case (s)
            0: begin
               @(negedge clk);
               ev_flat  = NUM'(1) << 2;
               clear    = 1'b1;
               snapshot = 1'b1;
               @(negedge clk);
               ev_flat  = '0;
               clear    = 1'b0;
               snapshot = 1'b0;
            end
            2: begin
               @(negedge clk);
               ev_flat = NUM'(1) << 2;
               @(negedge clk);
               ev_flat = '0;
               clear   = 1'b1;
               @(negedge clk);
               clear   = 1'b0;
            end
            default: ;
         endcase
         if (s > 0) snap();
         @(negedge clk);
         issue(2, mk(d[s], 0, 0), mk(d[s], 0, 0));
         @(negedge clk);
         rd_req = 1'b0;
         vectors++;
         es = q_s.pop_front();
         ew = q_w.pop_front();
         if (got_s() !== {1'b1, es} || got_w() !== {1'b1, ew}) begin
            miscompares++;
            $display("FAIL clear_snap stage %0d: sat %h want %h, wrap %h want %h", s, got_s(), {1'b1, es}, got_w(), {1'b1, ew});
         end
      end
   endtask

   task automatic test_enable();
      exp_t es, ew;
      int   ad[4];
      exp_t xp[4];
      ad = '{3, 14, 15, 4};
      xp = '{mk(2, 0, 0), mk(0, 0, 1), mk(0, 0, 1), mk(0, 0, 0)};
      clr();
      enable = 1'b0;
      pulses(NUM'(1) << 3, 10, 1'b1);
      enable = 1'b1;
      pulses(NUM'(1) << 3, 2, 1'b1);
      enable = 1'b0;
      snap();
      enable = 1'b1;
      pulses(NUM'(1) << 3, 1, 1'b1);
      enable = 1'b0;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            vectors++;
            es = q_s.pop_front();
            ew = q_w.pop_front();
            if (got_s() !== {1'b1, es} || got_w() !== {1'b1, ew}) begin
               miscompares++;
               $display("FAIL enable_rd addr %0d: sat %h want %h, wrap %h want %h", ad[i - 1], got_s(), {1'b1, es}, got_w(), {1'b1, ew});
            end
         end
         if (i < 4) issue(ad[i], xp[i], xp[i]);
         else rd_req = 1'b0;
      end
      enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      exp_t es, ew;
      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = AW'(3);
      rst     = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      vectors++;
      if (rd_s.rd_valid_o !== 1'b0 || rd_w.rd_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_valid: sat=%b wrap=%b want 0", rd_s.rd_valid_o, rd_w.rd_valid_o);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      snap();
      for (int i = 0; i <= int'(NUM); i++) begin
         @(negedge clk);
         if (i > 0) begin
            vectors++;
            es = q_s.pop_front();
            ew = q_w.pop_front();
            if (got_s() !== {1'b1, es} || got_w() !== {1'b1, ew}) begin
               miscompares++;
               $display("FAIL reset_mid_rd idx %0d: sat %h want %h, wrap %h want %h", i - 1, got_s(), {1'b1, es}, got_w(), {1'b1, ew});
            end
         end
         if (i < int'(NUM)) issue(i, mk(0, 0, 0), mk(0, 0, 0));
         else rd_req = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_overflow();
      test_clear_snapshot();
      test_enable();
      test_reset_mid();
      vectors++;
      if (q_s.size() != 0 || q_w.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d/%0d responses still pending, want 0", q_s.size(), q_w.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
